debug_tx_arbiter: RTL and testbench

DEBUG_TX_ARBITER -- requirements
Module: debug_tx_arbiter

---
 rtl/debug_tx_arbiter_pkg.sv | 28 ++
 rtl/debug_tx_arbiter_rr_picker.sv | 37 +++
 rtl/debug_tx_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_debug_tx_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_tx_arbiter_pkg.sv
// Shared definitions for the debug link transmit path: byte width, debug
// opcodes, arbiter state encoding and frame-length helpers.
package debug_tx_arbiter_pkg;

  localparam int UART_LEN = 8;
  localparam int LEN_W    = 3;

  localparam logic [UART_LEN-1:0] OP_SIGNAL = 8'h01;
  localparam logic [UART_LEN-1:0] OP_OK     = 8'h02;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } arb_state_t;

  // Lengths beyond the frame buffer are limited to the last valid byte index.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input logic [LEN_W-1:0] max_len);
    logic [LEN_W-1:0] res;
    if (len > max_len) begin
      res = max_len;
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/debug_tx_arbiter_rr_picker.sv
// Combinational round-robin selector: the first valid requester after the
// previous winner, scanning upward with wrap-around.
module rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_any
);

  int               w_cand;
  logic [IDX_W-1:0] w_cand_idx;

  // Scan offsets 1..NUM_REQ from the last grant; the first hit wins.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_cand      = 0;
    w_cand_idx  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_cand     = (int'(i_last_grant) + off) % NUM_REQ;
      w_cand_idx = IDX_W'(w_cand);
      if (!o_any && i_valid[w_cand_idx]) begin
        o_any               = 1'b1;
        o_grant[w_cand_idx] = 1'b1;
        o_grant_idx         = w_cand_idx;
      end else begin
        o_any = o_any;
      end
    end
  end

endmodule

// File: rtl/debug_tx_arbiter.sv
// Arbitrates debug frames from several requesters onto one byte transmitter,
// sending each latched frame byte by byte with a per-byte timeout.
module debug_tx_arbiter
  import debug_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int FRAME_BYTES    = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ*FRAME_BYTES*UART_LEN-1:0] req_data,
  input  logic [NUM_REQ*LEN_W-1:0]              req_len,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic                                  tx_start,
  output logic [UART_LEN-1:0]                   tx_byte,
  input  logic                                  tx_done,
  output logic                                  busy,
  output logic                                  frame_done,
  output logic                                  tx_error
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int FRAME_W = FRAME_BYTES * UART_LEN;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(FRAME_BYTES - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  arb_state_t          r_state;
  logic [IDX_W-1:0]    r_last_grant;
  logic [IDX_W-1:0]    r_cur_grant;
  logic [LEN_W-1:0]    r_idx;
  logic [LEN_W-1:0]    r_len;
  logic [CNT_W-1:0]    r_cnt;
  logic [FRAME_W-1:0]  r_frame;
  logic [NUM_REQ-1:0]  r_req_ready;
  logic                r_tx_start;
  logic [UART_LEN-1:0] r_tx_byte;
  logic                r_busy;
  logic                r_frame_done;
  logic                r_tx_error;

  arb_state_t          w_state_nxt;
  logic [IDX_W-1:0]    w_last_grant_nxt;
  logic [IDX_W-1:0]    w_cur_grant_nxt;
  logic [LEN_W-1:0]    w_idx_nxt;
  logic [LEN_W-1:0]    w_len_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [FRAME_W-1:0]  w_frame_nxt;
  logic [NUM_REQ-1:0]  w_req_ready_nxt;
  logic                w_tx_start_nxt;
  logic [UART_LEN-1:0] w_tx_byte_nxt;
  logic                w_busy_nxt;
  logic                w_frame_done_nxt;
  logic                w_tx_error_nxt;

  logic [NUM_REQ-1:0]  w_grant;
  logic [IDX_W-1:0]    w_grant_idx;
  logic                w_grant_any;
  logic [FRAME_W-1:0]  w_win_frame;
  logic [LEN_W-1:0]    w_win_len;
  logic [LEN_W-1:0]    w_next_idx;
  logic [UART_LEN-1:0] w_next_byte;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .i_valid      (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx),
    .o_any        (w_grant_any)
  );

  // Route the winning requester's frame and length toward the latch.
  always_comb begin
    w_win_frame = '0;
    w_win_len   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == IDX_W'(i)) begin
        w_win_frame = req_data[i*FRAME_W +: FRAME_W];
        w_win_len   = req_len[i*LEN_W +: LEN_W];
      end else begin
        w_win_frame = w_win_frame;
      end
    end
  end

  assign w_next_idx = r_idx + 3'd1;

  // Pick the byte that follows the current one out of the latched frame.
  always_comb begin
    w_next_byte = '0;
    for (int b = 0; b < FRAME_BYTES; b++) begin
      if (w_next_idx == LEN_W'(b)) begin
        w_next_byte = r_frame[b*UART_LEN +: UART_LEN];
      end else begin
        w_next_byte = w_next_byte;
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_cur_grant_nxt  = r_cur_grant;
    w_idx_nxt        = r_idx;
    w_len_nxt        = r_len;
    w_cnt_nxt        = r_cnt;
    w_frame_nxt      = r_frame;
    w_req_ready_nxt  = '0;
    w_tx_start_nxt   = 1'b0;
    w_tx_byte_nxt    = r_tx_byte;
    w_busy_nxt       = r_busy;
    w_frame_done_nxt = 1'b0;
    w_tx_error_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_any) begin
          w_state_nxt     = ST_WAIT;
          w_cur_grant_nxt = w_grant_idx;
          w_idx_nxt       = '0;
          w_len_nxt       = clamp_len(w_win_len, LEN_MAX);
          w_cnt_nxt       = '0;
          w_frame_nxt     = w_win_frame;
          w_req_ready_nxt = w_grant;
          w_tx_start_nxt  = 1'b1;
          w_tx_byte_nxt   = w_win_frame[UART_LEN-1:0];
          w_busy_nxt      = 1'b1;
        end else begin
          w_busy_nxt = 1'b0;
        end
      end
      ST_WAIT: begin
        // A completion on the timeout edge still counts as a completion.
        if (tx_done) begin
          if (r_idx < r_len) begin
            w_idx_nxt      = w_next_idx;
            w_cnt_nxt      = '0;
            w_tx_start_nxt = 1'b1;
            w_tx_byte_nxt  = w_next_byte;
          end else begin
            w_state_nxt      = ST_IDLE;
            w_frame_done_nxt = 1'b1;
            w_busy_nxt       = 1'b0;
            w_last_grant_nxt = r_cur_grant;
          end
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt      = ST_IDLE;
          w_tx_error_nxt   = 1'b1;
          w_busy_nxt       = 1'b0;
          w_last_grant_nxt = r_cur_grant;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= LAST_RST;
      r_cur_grant  <= '0;
      r_idx        <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_frame      <= '0;
      r_req_ready  <= '0;
      r_tx_start   <= 1'b0;
      r_tx_byte    <= 8'h00;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_tx_error   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_cur_grant  <= w_cur_grant_nxt;
      r_idx        <= w_idx_nxt;
      r_len        <= w_len_nxt;
      r_cnt        <= w_cnt_nxt;
      r_frame      <= w_frame_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_tx_start   <= w_tx_start_nxt;
      r_tx_byte    <= w_tx_byte_nxt;
      r_busy       <= w_busy_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_tx_error   <= w_tx_error_nxt;
    end
  end

  assign req_ready  = r_req_ready;
  assign tx_start   = r_tx_start;
  assign tx_byte    = r_tx_byte;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign tx_error   = r_tx_error;

endmodule

// File: tb/tb_debug_tx_arbiter.sv
// Directed and randomized bench for debug_tx_arbiter against a transaction-level
// reference model (round-robin by distance, per-frame byte list, timing rules).
module tb_debug_tx_arbiter;
  import debug_tx_arbiter_pkg::*;

  localparam int NR = 3;
  localparam int FB = 8;
  localparam int TO = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NR-1:0]        req_valid;
  logic [NR*FB*8-1:0]   req_data;
  logic [NR*3-1:0]      req_len;
  logic [NR-1:0]        req_ready;
  logic                 tx_start;
  logic [7:0]           tx_byte;
  logic                 tx_done;
  logic                 busy;
  logic                 frame_done;
  logic                 tx_error;

  always #5 clk = ~clk;

  debug_tx_arbiter #(
    .NUM_REQ        (NR),
    .FRAME_BYTES    (FB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_len    (req_len),
    .req_ready  (req_ready),
    .tx_start   (tx_start),
    .tx_byte    (tx_byte),
    .tx_done    (tx_done),
    .busy       (busy),
    .frame_done (frame_done),
    .tx_error   (tx_error)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int       model_last = NR - 1;
  int       cur_win;
  int       cur_len;
  logic [7:0] cur_bytes [FB];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Winner = valid requester at the smallest forward distance from the last grant.
  function automatic int model_pick(input logic [NR-1:0] v, input int last);
    int best;
    int bd;
    int d;
    best = -1;
    bd   = NR;
    for (int i = 0; i < NR; i++) begin
      if (v[i]) begin
        d = (i - last - 1 + 2 * NR) % NR;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic scramble_data();
    for (int i = 0; i < NR * FB * 8 / 32; i++) req_data[i*32 +: 32] = $urandom();
  endtask

  task automatic request(input logic [NR-1:0] vld, input bit hold, input int exp_lat, output int win);
    int lat;
    int lf;
    logic [NR-1:0] exp_oh;
    win = model_pick(vld, model_last);
    cur_win = win;
    lf = int'(req_len[win*3 +: 3]);
    cur_len = (lf > FB - 1) ? FB - 1 : lf;
    for (int b = 0; b < FB; b++) cur_bytes[b] = req_data[(win*FB + b)*8 +: 8];
    exp_oh = NR'(1) << win;
    req_valid = vld;
    tick();
    lat = 1;
    while (req_ready == '0 && lat < 4) begin
      tick();
      lat++;
    end
    check("grant_onehot", req_ready, exp_oh);
    check("grant_busy", busy, 1);
    if (exp_lat > 0) check("grant_latency", lat, exp_lat);
    if (!hold) begin
      req_valid = '0;
      req_len   = NR*3'($urandom());
    end
    scramble_data();
  endtask

  // mode: 0 normal, 1 timeout at mode_byte, 2 race at mode_byte, 3 reset at mode_byte, 4 late request glitch
  task automatic serve(input int mode, input int mode_byte);
    int d;
    for (int b = 0; b <= cur_len; b++) begin
      check("tx_start", tx_start, 1);
      check("tx_byte", tx_byte, cur_bytes[b]);
      check("busy_in_frame", busy, 1);
      if (mode == 1 && b == mode_byte) begin
        repeat (TO - 1) tick();
        check("timeout_early", tx_error, 0);
        check("timeout_busy_hold", busy, 1);
        tick();
        check("timeout_error", tx_error, 1);
        check("timeout_busy", busy, 0);
        check("timeout_no_done", frame_done, 0);
        model_last = cur_win;
        return;
      end
      if (mode == 3 && b == mode_byte) begin
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_req_ready", req_ready, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_tx_error", tx_error, 0);
        model_last = NR - 1;
        tick();
        check("rst_after_pulses", {frame_done, tx_error, busy}, 0);
        return;
      end
      d = (mode == 2 && b == mode_byte) ? TO - 1 : int'($urandom_range(0, 6));
      if (mode == 4 && b == 0) begin
        req_valid = 3'b100;
        if (d == 0) d = 1;
      end
      for (int t = 0; t < d; t++) begin
        tick();
        if (t == 0) check("tx_start_pulse", tx_start, 0);
      end
      if (mode == 4 && b == 0) req_valid = '0;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check("no_tx_error", tx_error, 0);
      if (b < cur_len) begin
        check("frame_done_early", frame_done, 0);
      end else begin
        check("frame_done", frame_done, 1);
        check("done_busy", busy, 0);
        check("done_tx_start", tx_start, 0);
        model_last = cur_win;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int fair_order [4];
    logic [NR-1:0] seen;
    int r;
    int mode;
    fair_order = '{0, 1, 2, 0};
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_len = '0;
    tx_done = 1'b0;
    repeat (2) tick();
    check("reset_req_ready", req_ready, 0);
    check("reset_tx_start", tx_start, 0);
    check("reset_tx_byte", tx_byte, 8'h00);
    check("reset_busy", busy, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_tx_error", tx_error, 0);
    rst = 1'b0;
    tick();

    // tx_done while idle is ignored
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    check("idle_txdone", {req_ready, tx_start, busy, frame_done, tx_error}, 0);

    // Fairness: all requesting, single-byte frames
    req_len = '0;
    scramble_data();
    for (int k = 0; k < 4; k++) begin
      request(3'b111, 1'b1, 1, w);
      check("fair_order", w, fair_order[k]);
      serve(0, 0);
    end
    req_valid = '0;
    tick();

    // Single-byte frame from requester 1 carrying OP_OK
    req_data[1*64 +: 8] = OP_OK;
    req_len[3 +: 3] = 3'd0;
    request(3'b010, 1'b0, 1, w);
    check("single_ready", w, 1);
    check("single_byte", tx_byte, 8'h02);
    serve(0, 0);

    // Eight-byte frame from requester 0, race on byte 2
    req_data[0 +: 64] = 64'h0706050403020100;
    req_len[0 +: 3] = 3'd7;
    request(3'b001, 1'b0, 1, w);
    for (int b = 0; b < 8; b++) check("multi_model", cur_bytes[b], b);
    serve(2, 2);

    // Request raised and dropped while busy produces nothing
    req_len[0 +: 3] = 3'd1;
    request(3'b001, 1'b0, 1, w);
    serve(4, 0);
    seen = '0;
    for (int t = 0; t < 4; t++) begin
      tick();
      seen = seen | req_ready;
    end
    check("dropped_no_grant", {seen, tx_start, busy}, 0);

    // Timeout on byte 1, then next grant goes to the following requester
    req_len[0 +: 3] = 3'd2;
    request(3'b001, 1'b0, 1, w);
    serve(1, 1);
    request(3'b111, 1'b0, 1, w);
    check("timeout_next_grant", w, 1);
    serve(0, 0);

    // Race on the last byte
    req_len[0 +: 3] = 3'd1;
    request(3'b001, 1'b0, 1, w);
    serve(2, 1);

    // Reset mid-frame at byte 3 of 8, then 3'b101 goes to requester 0
    req_len[3 +: 3] = 3'd7;
    request(3'b010, 1'b0, 1, w);
    serve(3, 3);
    request(3'b101, 1'b0, 1, w);
    check("post_reset_grant", w, 0);
    serve(0, 0);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      req_len = NR*3'($urandom());
      scramble_data();
      request(NR'($urandom_range(1, 7)), 1'b0, 1, w);
      r = int'($urandom_range(0, 5));
      mode = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
      serve(mode, int'($urandom_range(0, cur_len)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
